pre_decode: RTL
===============

PRE_DECODE -- requirements
Module: pre_decode

Interface
REQ-001 Parameter RAS_DEPTH, default 4, number of return-address-stack entries (power of two, >=2).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 FpD_valid  input  1  fetch-stage output valid.
REQ-005 FpD_BUS  input  75  fetch payload: pc[74:43], inst[42:11], fetch-req[10] (ignored), ex[9], ecode[8:1], esubcode[0].
REQ-006 pD_allowin  output  1  stage can accept FpD_BUS this cycle.
REQ-007 predict_BUS  output  33  {taken[32], target[31:0]}, redirect request to fetch.
REQ-008 predict_error  input  1  execute-stage misprediction flush.
REQ-009 ex_flush  input  1  exception/ertn flush.
REQ-010 D_allowin  input  1  decode stage can accept.
REQ-011 pDD_valid  output  1  payload to decode valid.
REQ-012 pDD_BUS  output  107  {pc[106:75], inst[74:43], pred_taken[42], pred_target[41:10], ex[9], ecode[8:1], esubcode[0]}.

Function
REQ-013 Ready_go always 1; pD_allowin = !pD_valid || D_allowin.
REQ-014 accept = FpD_valid && pD_allowin && !predict_error && !ex_flush; on accept, register captures pc, inst, ex fields and prediction; pD_valid<=1 next cycle; latency 1 cycle.
REQ-015 If D_allowin and no accept, pD_valid<=0; if !D_allowin, register holds (no overwrite).
REQ-016 predict_error or ex_flush: pD_valid<=0 next cycle, no capture, predict_BUS.taken=0 that cycle; flush has priority over accept.
REQ-017 Classification from inst[31:26]: B 010100, BL 010101, BEQ..BGEU 010110..011011, JIRL 010011; return = JIRL with rd(inst[4:0])=0, rj(inst[9:5])=1, offs16=0.
REQ-018 B/BL: taken=1, target = pc + sext({inst[9:0],inst[25:10],2'b00}), 32-bit wrap-around.
REQ-019 Conditional: taken = offs16 sign bit (inst[25]) (backward taken), target = pc + sext({inst[25:10],2'b00}).
REQ-020 Return: taken=1 if RAS non-empty, target = RAS top; RAS empty -> taken=0, target=0.
REQ-021 Other JIRL, non-branches, or ex=1: taken=0, target=0; no RAS update.
REQ-022 predict_BUS combinational, valid only in accept cycle; taken=0 otherwise; target=0 whenever taken=0.
REQ-023 RAS: BL accepted pushes pc+4; return accepted with count>0 pops; pointer wraps modulo RAS_DEPTH.
REQ-024 Push when full overwrites oldest entry, count saturates at RAS_DEPTH; pop when empty does nothing.
REQ-025 predict_error clears RAS (count=0, ptr=0) next cycle; ex_flush leaves RAS unchanged.
REQ-026 pDD_BUS fields driven from register; pred_taken/pred_target carry the prediction sent to fetch.

Reset
REQ-027 rstn=0 at clock edge: pD_valid=0, payload register=0, RAS count=0, pointer=0, entries don't-care.
REQ-028 During/after reset: pDD_valid=0, pDD_BUS=0, predict_BUS=0, pD_allowin=1.
REQ-029 Reset mid-operation discards held instruction and RAS contents; first accept after release behaves as from empty.

Structure
REQ-030 Opcode constants, FpD_BUS_Wid (75), pDD_BUS_Wid (107), predict_BUS_Wid (33) live in shared Defines.vh.
REQ-031 One sub-module pd_ras (push, pop, clear, top, empty; RAS_DEPTH param); classification and target adders stay in pre_decode.

Verification
REQ-032 B at pc 0x1c000000, offs26=+4 (inst 0x50001000): accept -> predict_BUS={1,0x1c000010} same cycle, pDD_valid=1 next cycle with pred_taken=1.
REQ-033 BEQ offs16=0xFFFF at pc 0x1c000100 -> taken=1, target 0x1c0000FC; offs16=+1 -> taken=0, target=0.
REQ-034 BL at 0x1c000200 then return (0x4C000020) -> return predicts 0x1c000204; second return with empty RAS -> taken=0.
REQ-035 Five BLs (pc 0x100,0x200,0x300,0x400,0x500), RAS_DEPTH=4, five returns -> targets 0x504,0x404,0x304,0x204, then not-taken.
REQ-036 D_allowin=0 two cycles with FpD_valid=1 -> pD_allowin=0, pDD_BUS stable, no predict_BUS pulse; release -> next instruction accepted.
REQ-037 predict_error coincident with FpD_valid of BL -> no capture, no push, taken=0, RAS count=0, pDD_valid=0 next cycle.

Source files
------------

// File: rtl/pre_decode_pkg.sv
// Shared widths, opcodes, payload layouts and branch classification for the
// pre-decode stage that sits between fetch and decode.
package pre_decode_pkg;

    localparam int FpD_BUS_Wid     = 75;
    localparam int pDD_BUS_Wid     = 107;
    localparam int predict_BUS_Wid = 33;

    localparam logic [5:0] OP_JIRL = 6'b010011;
    localparam logic [5:0] OP_B    = 6'b010100;
    localparam logic [5:0] OP_BL   = 6'b010101;
    localparam logic [5:0] OP_BEQ  = 6'b010110;
    localparam logic [5:0] OP_BNE  = 6'b010111;
    localparam logic [5:0] OP_BLT  = 6'b011000;
    localparam logic [5:0] OP_BGE  = 6'b011001;
    localparam logic [5:0] OP_BLTU = 6'b011010;
    localparam logic [5:0] OP_BGEU = 6'b011011;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_B    = 3'd1,
        BR_BL   = 3'd2,
        BR_COND = 3'd3,
        BR_RET  = 3'd4,
        BR_JIRL = 3'd5
    } br_kind_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fetch_req;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
    } fetch_pkt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
    } pdd_pkt_t;

    // A return is the canonical "jirl r0, r1, 0"; any other jirl is not predicted.
    function automatic br_kind_e classify(input logic [31:0] inst);
        br_kind_e kind;
        kind = BR_NONE;
        case (inst[31:26])
            OP_B:    kind = BR_B;
            OP_BL:   kind = BR_BL;
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                     kind = BR_COND;
            OP_JIRL: begin
                if (inst[4:0] == 5'd0 && inst[9:5] == 5'd1 && inst[25:10] == 16'd0) begin
                    kind = BR_RET;
                end else begin
                    kind = BR_JIRL;
                end
            end
            default: kind = BR_NONE;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/pd_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest
// entry and the occupancy count saturates.
module pd_ras #(
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        clear_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

    logic [31:0]   entry_q [RAS_DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] top_idx_s;

    // ptr_q is the next free slot, so the top sits one below it
    assign top_idx_s = ptr_q - PTR_ONE;
    assign top_o     = entry_q[top_idx_s];
    assign empty_o   = (cnt_q == {CW{1'b0}});

    // Pointer and occupancy next-state.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = {PW{1'b0}};
            cnt_d = {CW{1'b0}};
        end else if (push_i) begin
            ptr_d = ptr_q + PTR_ONE;
            if (cnt_q == CNT_FULL) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ptr_q <= {PW{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; written only by a push.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entry_q[i] <= 32'd0;
            end
        end else if (push_i && !clear_i) begin
            entry_q[ptr_q] <= push_data_i;
        end else begin
            entry_q[ptr_q] <= entry_q[ptr_q];
        end
    end

endmodule

// File: rtl/pre_decode.sv
// Pre-decode stage: static branch prediction on the fetched instruction, a
// same-cycle redirect to fetch, and a one-entry pipeline register to decode.
module pre_decode
    import pre_decode_pkg::*;
#(
    parameter int RAS_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       FpD_valid,
    input  logic [FpD_BUS_Wid-1:0]     FpD_BUS,
    output logic                       pD_allowin,
    output logic [predict_BUS_Wid-1:0] predict_BUS,
    input  logic                       predict_error,
    input  logic                       ex_flush,
    input  logic                       D_allowin,
    output logic                       pDD_valid,
    output logic [pDD_BUS_Wid-1:0]     pDD_BUS
);

    fetch_pkt_t  fpd_s;
    br_kind_e    kind_s;
    logic        unused_s;
    logic        accept_s;
    logic        flush_s;
    logic        taken_s;
    logic [31:0] target_s;
    logic [31:0] off26_s;
    logic [31:0] off16_s;
    logic [31:0] b_target_s;
    logic [31:0] c_target_s;
    logic [31:0] link_s;
    logic        ras_push_s;
    logic        ras_pop_s;
    logic [31:0] ras_top_s;
    logic        ras_empty_s;

    logic        pd_valid_q, pd_valid_d;
    pdd_pkt_t    payload_q, payload_d;

    assign fpd_s    = FpD_BUS;
    assign unused_s = fpd_s.fetch_req;
    assign kind_s   = classify(fpd_s.inst);

    assign off26_s    = {{4{fpd_s.inst[9]}}, fpd_s.inst[9:0], fpd_s.inst[25:10], 2'b00};
    assign off16_s    = {{14{fpd_s.inst[25]}}, fpd_s.inst[25:10], 2'b00};
    assign b_target_s = fpd_s.pc + off26_s;
    assign c_target_s = fpd_s.pc + off16_s;
    assign link_s     = fpd_s.pc + 32'd4;

    assign pD_allowin = !pd_valid_q || D_allowin;
    assign flush_s    = predict_error || ex_flush;
    assign accept_s   = rstn && FpD_valid && pD_allowin && !flush_s;

    // Static prediction: unconditional taken, conditional backward taken, return via RAS.
    always_comb begin
        taken_s  = 1'b0;
        target_s = 32'd0;
        if (fpd_s.ex) begin
            taken_s  = 1'b0;
            target_s = 32'd0;
        end else begin
            case (kind_s)
                BR_B, BR_BL: begin
                    taken_s  = 1'b1;
                    target_s = b_target_s;
                end
                BR_COND: begin
                    if (fpd_s.inst[25]) begin
                        taken_s  = 1'b1;
                        target_s = c_target_s;
                    end else begin
                        taken_s  = 1'b0;
                        target_s = 32'd0;
                    end
                end
                BR_RET: begin
                    if (!ras_empty_s) begin
                        taken_s  = 1'b1;
                        target_s = ras_top_s;
                    end else begin
                        taken_s  = 1'b0;
                        target_s = 32'd0;
                    end
                end
                default: begin
                    taken_s  = 1'b0;
                    target_s = 32'd0;
                end
            endcase
        end
    end

    assign predict_BUS = accept_s ? {taken_s, target_s} : {predict_BUS_Wid{1'b0}};

    assign ras_push_s = accept_s && !fpd_s.ex && (kind_s == BR_BL);
    assign ras_pop_s  = accept_s && !fpd_s.ex && (kind_s == BR_RET);

    pd_ras #(
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (ras_push_s),
        .pop_i       (ras_pop_s),
        .clear_i     (predict_error),
        .push_data_i (link_s),
        .top_o       (ras_top_s),
        .empty_o     (ras_empty_s)
    );

    // Stage register next-state; a flush wins over a same-cycle accept.
    always_comb begin
        pd_valid_d = pd_valid_q;
        payload_d  = payload_q;
        if (flush_s) begin
            pd_valid_d = 1'b0;
        end else if (accept_s) begin
            pd_valid_d            = 1'b1;
            payload_d.pc          = fpd_s.pc;
            payload_d.inst        = fpd_s.inst;
            payload_d.pred_taken  = taken_s;
            payload_d.pred_target = target_s;
            payload_d.ex          = fpd_s.ex;
            payload_d.ecode       = fpd_s.ecode;
            payload_d.esubcode    = fpd_s.esubcode;
        end else if (D_allowin) begin
            pd_valid_d = 1'b0;
        end else begin
            pd_valid_d = pd_valid_q;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pd_valid_q <= 1'b0;
            payload_q  <= '0;
        end else begin
            pd_valid_q <= pd_valid_d;
            payload_q  <= payload_d;
        end
    end

    assign pDD_valid = pd_valid_q;
    assign pDD_BUS   = payload_q;

endmodule
